// File: rtl/ipg_tx_inserter.sv
// Substitutes buffered IPG reply chunks into all-idle XGMII words in the inter-packet gap.
// Applies fill-level hysteresis to tx_pause as back-pressure toward the MAC.
module ipg_tx_inserter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned MIN_IDLE_WORDS = 1,
  parameter int unsigned PAUSE_THRESH   = 12,
  parameter int unsigned RESUME_THRESH  = 4,
  localparam int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
  localparam int unsigned AW            = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memq_write,
  input  logic [DATA_WIDTH-1:0] ipg_reply_chunk,
  input  logic [DATA_WIDTH-1:0] xgmii_txd,
  input  logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic [DATA_WIDTH-1:0] out_txd,
  output logic [CTRL_WIDTH-1:0] out_txc,
  output logic                  out_ipg_valid,
  output logic                  tx_pause,
  output logic [AW:0]           fifo_level,
  output logic                  drop_pulse
);

  localparam int unsigned IW = (MIN_IDLE_WORDS < 1) ? 1 : $clog2(MIN_IDLE_WORDS + 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{8'h07}};
  localparam logic [CTRL_WIDTH-1:0] ALL_CTRL  = '1;

  typedef enum logic [0:0] {ST_GAP, ST_FRAME} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         idle_cnt, idle_cnt_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  is_idle, is_start, is_term;
  logic                  full, empty, push, pop, drop;

  // Word classification of the incoming MAC stream
  always_comb begin
    is_idle  = (xgmii_txc == ALL_CTRL) && (xgmii_txd == IDLE_WORD);
    is_start = (xgmii_txc[0] && (xgmii_txd[7:0] == 8'hFB)) ||
               (xgmii_txc[4] && (xgmii_txd[39:32] == 8'hFB));
    is_term  = 1'b0;
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      if (xgmii_txc[i] && (xgmii_txd[i*8 +: 8] == 8'hFD)) is_term = 1'b1;
    end
  end

  always_comb begin
    full  = (level == (AW+1)'(FIFO_DEPTH));
    empty = (level == '0);
    push  = memq_write && (!full || pop);
    drop  = memq_write && full && !pop;
  end

  // Gap/frame tracking and the insert decision (pop)
  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    pop           = 1'b0;
    case (state)
      ST_GAP: begin
        if (is_start) begin
          state_next    = ST_FRAME;
          idle_cnt_next = '0;
        end else if (is_idle) begin
          pop = (idle_cnt >= IW'(MIN_IDLE_WORDS)) && !empty;
          if (idle_cnt < IW'(MIN_IDLE_WORDS)) idle_cnt_next = IW'(idle_cnt + 1'b1);
        end
      end
      ST_FRAME: begin
        if (is_start) idle_cnt_next = '0;
        if (is_term && !is_start) state_next = ST_GAP;
      end
      default: state_next = ST_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_GAP;
      idle_cnt <= IW'(MIN_IDLE_WORDS);
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  // Storage has no reset; validity is carried entirely by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ipg_reply_chunk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= AW'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   level <= (AW+1)'(level + 1'b1);
        2'b01:   level <= (AW+1)'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_txd       <= IDLE_WORD;
      out_txc       <= ALL_CTRL;
      out_ipg_valid <= 1'b0;
      drop_pulse    <= 1'b0;
      tx_pause      <= 1'b0;
    end else begin
      out_txd       <= pop ? mem[rd_ptr] : xgmii_txd;
      out_txc       <= pop ? ALL_CTRL : xgmii_txc;
      out_ipg_valid <= pop;
      drop_pulse    <= drop;
      if (level >= (AW+1)'(PAUSE_THRESH))       tx_pause <= 1'b1;
      else if (level < (AW+1)'(RESUME_THRESH))  tx_pause <= 1'b0;
    end
  end

  assign fifo_level = level;

endmodule
